// File: rtl/instruction_fetch_unit.sv
// Fetch stage: takes the next PC, runs a req/ack read against instruction memory,
// and hands the word plus its PC to decode over valid/ready, back-pressuring the PC source.
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    TIMEOUT    = 15,
    parameter logic [DATA_WIDTH-1:0] NOP        = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  addr_valid,
    output logic                  stall,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  imem_ack,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  flush,
    output logic                  fetch_err
);

    // state | meaning
    // IDLE  | no fetch outstanding, ready to accept a PC
    // REQ   | request outstanding, result will be presented
    // DROP  | request outstanding after flush, result discarded
    // HOLD  | instruction presented to decode, waiting for ready
    // ERR   | timeout or misaligned PC, terminal until reset
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_DROP, S_HOLD, S_ERR} state_t;

    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               can_take;
    logic               accept;
    logic               aligned;
    logic               timeout_hit;
    logic               in_flight;
    logic               in_flight_next;

    assign can_take       = (state == S_IDLE) || ((state == S_HOLD) && instr_ready);
    assign accept         = addr_valid && !flush && can_take;
    assign aligned        = (addr[1:0] == 2'b00);
    assign timeout_hit    = (cnt == CNT_W'(TIMEOUT - 1));
    assign in_flight      = (state == S_REQ) || (state == S_DROP);
    assign in_flight_next = (state_next == S_REQ) || (state_next == S_DROP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) state_next = aligned ? S_REQ : S_ERR;
            end
            S_REQ: begin
                if (imem_ack)         state_next = flush ? S_IDLE : S_HOLD;
                else if (flush)       state_next = S_DROP;
                else if (timeout_hit) state_next = S_ERR;
            end
            S_DROP: begin
                if (imem_ack)         state_next = S_IDLE;
                else if (timeout_hit) state_next = S_ERR;
            end
            S_HOLD: begin
                if (flush)            state_next = S_IDLE;
                else if (instr_ready) state_next = accept ? (aligned ? S_REQ : S_ERR) : S_IDLE;
            end
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = in_flight;
        instr_valid = (state == S_HOLD);
        fetch_err   = (state == S_ERR);
        stall       = !can_take || flush;
    end

    // The timeout budget carries across REQ -> DROP; it restarts only when the request ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_addr   <= '0;
            pc_out      <= '0;
            instruction <= NOP;
            cnt         <= '0;
        end else begin
            if (accept && aligned) begin
                imem_addr <= addr;
                pc_out    <= addr;
            end
            if ((state == S_REQ) && imem_ack && !flush) begin
                instruction <= imem_rdata;
                pc_out      <= imem_addr;
            end
            if ((state == S_HOLD) && flush) begin
                instruction <= NOP;
            end
            if (in_flight && in_flight_next) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: inputs change on the falling edge,
// outputs are checked 1ns later, so each check sees the state of the current cycle.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        addr_valid;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(15), .NOP(32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .addr_valid(addr_valid), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .instruction(instruction), .pc_out(pc_out),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .flush(flush),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0; addr_valid = 1'b0; imem_ack = 1'b0; flush = 1'b0; instr_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; addr = 32'h0; addr_valid = 1'b1; imem_ack = 1'b0; imem_rdata = 32'hDEAD_0000;
        flush = 1'b0; instr_ready = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b valid=%b err=%b stall=%b, want 0 0 0 0",
                     imem_req, instr_valid, fetch_err, stall);
        end
        checks++;
        if (instruction !== 32'h0 || pc_out !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: instr=%h pc=%h iaddr=%h, want all 0", instruction, pc_out, imem_addr);
        end
        tick();
        rst = 1'b1;
        tick();
        addr_valid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_req: req=%b iaddr=%h stall=%b, want 1 00000000 1", imem_req, imem_addr, stall);
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b1 || instruction !== 32'hDEAD_0000 || pc_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_instr: valid=%b instr=%h pc=%h, want 1 dead0000 00000000",
                     instr_valid, instruction, pc_out);
        end
        tick();
    endtask

    task automatic test_single_fetch();
        addr = 32'h0000_0004; addr_valid = 1'b1; instr_ready = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_stall: stall=%b, want 0", stall);
        end
        tick();
        addr_valid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || stall !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_req1: req=%b iaddr=%h stall=%b valid=%b, want 1 00000004 1 0",
                     imem_req, imem_addr, stall, instr_valid);
        end
        tick();
        #1;
        checks++;
        if (imem_req !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL single_req2: req=%b stall=%b, want 1 1", imem_req, stall);
        end
        imem_rdata = 32'h8C08_0010; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b1 || instruction !== 32'h8C08_0010 || pc_out !== 32'h4 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL single_result: valid=%b instr=%h pc=%h req=%b, want 1 8c080010 00000004 0",
                     instr_valid, instruction, pc_out, imem_req);
        end
    endtask

    task automatic test_backpressure();
        addr = 32'h0000_0008; addr_valid = 1'b1; instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (instr_valid !== 1'b1 || instruction !== 32'h8C08_0010 || pc_out !== 32'h4 ||
                stall !== 1'b1 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b instr=%h pc=%h stall=%b req=%b, want 1 8c080010 00000004 1 0",
                         i, instr_valid, instruction, pc_out, stall, imem_req);
            end
            tick();
        end
        instr_ready = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL bp_release_stall: stall=%b, want 0", stall);
        end
        tick();
        addr_valid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_req: req=%b iaddr=%h valid=%b, want 1 00000008 0", imem_req, imem_addr, instr_valid);
        end
        imem_rdata = 32'h1111_1111; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b1 || instruction !== 32'h1111_1111 || pc_out !== 32'h8) begin
            errors++;
            $display("FAIL bp_next_result: valid=%b instr=%h pc=%h, want 1 11111111 00000008",
                     instr_valid, instruction, pc_out);
        end
        tick();
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL bp_consumed: valid=%b req=%b stall=%b, want 0 0 0", instr_valid, imem_req, stall);
        end
    endtask

    task automatic test_flush();
        addr = 32'h0000_0010; addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0; flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL flush_in_req: stall=%b req=%b, want 1 1", stall, imem_req);
        end
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (imem_req !== 1'b1 || instr_valid !== 1'b0 || stall !== 1'b1) begin
                errors++;
                $display("FAIL flush_drop[%0d]: req=%b valid=%b stall=%b, want 1 0 1", i, imem_req, instr_valid, stall);
            end
            tick();
        end
        imem_rdata = 32'h1234_5678; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'h1111_1111) begin
            errors++;
            $display("FAIL flush_discard: req=%b valid=%b instr=%h, want 0 0 11111111", imem_req, instr_valid, instruction);
        end
        tick();
        #1;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_present: valid=%b, want 0", instr_valid);
        end
        addr = 32'h0000_1000; addr_valid = 1'b1; instr_ready = 1'b0;
        tick();
        addr_valid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h1000) begin
            errors++;
            $display("FAIL flush_refetch_req: req=%b iaddr=%h, want 1 00001000", imem_req, imem_addr);
        end
        imem_rdata = 32'hAABB_CCDD; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b1 || instruction !== 32'hAABB_CCDD || pc_out !== 32'h1000) begin
            errors++;
            $display("FAIL flush_refetch_result: valid=%b instr=%h pc=%h, want 1 aabbccdd 00001000",
                     instr_valid, instruction, pc_out);
        end
        flush = 1'b1; instr_ready = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || instruction !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_hold: valid=%b instr=%h req=%b, want 0 00000000 0", instr_valid, instruction, imem_req);
        end
    endtask

    task automatic test_timeout();
        addr = 32'h0000_0020; addr_valid = 1'b1;
        tick();
        for (int i = 1; i <= 15; i++) begin
            #1;
            checks++;
            if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: req=%b err=%b, want 1 0", i, imem_req, fetch_err);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || stall !== 1'b1 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_err[%0d]: err=%b req=%b stall=%b valid=%b, want 1 0 1 0",
                         i, fetch_err, imem_req, stall, instr_valid);
            end
            tick();
        end
        do_reset();
        #1;
        checks++;
        if (fetch_err !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cleared: err=%b stall=%b, want 0 0", fetch_err, stall);
        end
    endtask

    task automatic test_misaligned();
        addr = 32'h0000_0006; addr_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || stall !== 1'b1) begin
                errors++;
                $display("FAIL misaligned[%0d]: err=%b req=%b stall=%b, want 1 0 1", i, fetch_err, imem_req, stall);
            end
            addr = 32'h0000_0040;
            tick();
        end
        do_reset();
        #1;
        checks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_cleared: err=%b req=%b, want 0 0", fetch_err, imem_req);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_backpressure();
        test_flush();
        test_timeout();
        test_misaligned();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
